// File: rtl/proc_pkg.sv
// Shared definitions for the proc_core CPU: opcode constants, FSM state
// encoding, status-register bit positions, decoder result types and a
// helper that updates the N/Z flags from a result byte.
package proc_pkg;

  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_INX     = 8'hE8;
  localparam logic [7:0] OP_DEX     = 8'hCA;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;

  // Status register layout NV1BDIZC
  localparam int P_N = 7;
  localparam int P_Z = 1;

  typedef enum logic [2:0] {
    ST_VEC_LO,
    ST_VEC_HI,
    ST_FETCH,
    ST_IMPL,
    ST_OPER1,
    ST_OPER2,
    ST_WRITE,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    CLS_IMPL,
    CLS_IMM,
    CLS_ABS,
    CLS_ILLEGAL
  } op_class_e;

  typedef enum logic [1:0] {
    DST_NONE,
    DST_A,
    DST_X,
    DST_Y
  } dest_e;

  // Returns p with N and Z replaced according to result r; other bits kept.
  function automatic logic [7:0] set_nz(logic [7:0] p, logic [7:0] r);
    logic [7:0] q;
    q      = p;
    q[P_N] = r[7];
    q[P_Z] = (r == 8'h00);
    return q;
  endfunction

endpackage

// File: rtl/proc_if.sv
// Single memory port of the CPU.
//   rdy      slave->master  bus cycle completes on a clock edge with rdy=1
//   rd_data  slave->master  byte at the current address
//   address  master->slave  registered bus address
//   wr_data  master->slave  write data, valid while wr_en=1
//   wr_en    master->slave  current bus cycle is a write
//   sync     master->slave  current bus cycle is an opcode fetch
interface proc_if;
  logic        rdy;
  logic [7:0]  rd_data;
  logic [15:0] address;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        sync;

  modport master (input rdy, rd_data, output address, wr_data, wr_en, sync);
  modport slave  (output rdy, rd_data, input address, wr_data, wr_en, sync);
endinterface

// File: rtl/proc_decoder.sv
// Combinational opcode decoder.
//   op_i     opcode byte
//   cls_o    instruction class (implied / immediate / absolute / illegal)
//   dest_o   register written by the instruction (DST_NONE if none)
//   legal_o  opcode is implemented
module proc_decoder
  import proc_pkg::*;
(
  input  logic [7:0] op_i,
  output op_class_e  cls_o,
  output dest_e      dest_o,
  output logic       legal_o
);

  always_comb begin
    cls_o  = CLS_ILLEGAL;
    dest_o = DST_NONE;
    case (op_i)
      OP_NOP:     cls_o = CLS_IMPL;
      OP_INX,
      OP_DEX:     begin cls_o = CLS_IMPL; dest_o = DST_X; end
      OP_LDA_IMM: begin cls_o = CLS_IMM;  dest_o = DST_A; end
      OP_LDX_IMM: begin cls_o = CLS_IMM;  dest_o = DST_X; end
      OP_LDY_IMM: begin cls_o = CLS_IMM;  dest_o = DST_Y; end
      OP_JMP_ABS,
      OP_STA_ABS: cls_o = CLS_ABS;
      default:    ;
    endcase
  end

  assign legal_o = (cls_o != CLS_ILLEGAL);

endmodule

// File: rtl/proc_core.sv
// Multi-cycle 8-bit CPU (6502 subset) with a 16-bit address bus.
//   clk       clock
//   resetn    asynchronous active-low reset
//   bus       memory port (proc_if master)
//   halted    illegal opcode trapped; held until reset
//   a_reg, x_reg, y_reg, p_reg  architectural registers
//
// state     | meaning
// VEC_LO    | reading reset vector low byte
// VEC_HI    | reading reset vector high byte
// FETCH     | opcode fetch (sync=1)
// IMPL      | execute implied instruction
// OPER1     | first operand byte (immediate value or absolute low)
// OPER2     | absolute high byte; JMP completes, STA issues write
// WRITE     | write cycle on the bus
// HALT      | trapped on illegal opcode
module proc_core
  import proc_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = 16'hFFFC,
  parameter logic [15:0] TRAP_ADDR = 16'hFFFF,
  parameter logic [7:0]  P_RESET   = 8'h34
) (
  input  logic       clk,
  input  logic       resetn,
  proc_if.master     bus,
  output logic       halted,
  output logic [7:0] a_reg,
  output logic [7:0] x_reg,
  output logic [7:0] y_reg,
  output logic [7:0] p_reg
);

  state_e      state_q;
  logic [15:0] pc_q, addr_q;
  logic [7:0]  ir_q, lo_q, a_q, x_q, y_q, p_q, wr_data_q;
  logic        wr_en_q, sync_q, halted_q;

  op_class_e   dec_cls;
  dest_e       dec_dest;
  logic        dec_legal;
  logic [7:0]  dec_op, x_step;
  logic [15:0] pc_inc;

  // In FETCH the opcode is still on the bus; afterwards it lives in IR.
  assign dec_op = (state_q == ST_FETCH) ? bus.rd_data : ir_q;
  assign pc_inc = pc_q + 16'd1;
  assign x_step = (ir_q == OP_DEX) ? x_q - 8'd1 : x_q + 8'd1;

  proc_decoder u_dec (
    .op_i    (dec_op),
    .cls_o   (dec_cls),
    .dest_o  (dec_dest),
    .legal_o (dec_legal)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_VEC_LO;
      pc_q      <= 16'h0000;
      addr_q    <= RESET_VEC;
      ir_q      <= 8'h00;
      lo_q      <= 8'h00;
      a_q       <= 8'h00;
      x_q       <= 8'h00;
      y_q       <= 8'h00;
      p_q       <= P_RESET;
      wr_data_q <= 8'h00;
      wr_en_q   <= 1'b0;
      sync_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else if (state_q == ST_HALT) begin
      // Trap holds regardless of rdy.
      addr_q   <= TRAP_ADDR;
      wr_en_q  <= 1'b0;
      sync_q   <= 1'b0;
      halted_q <= 1'b1;
    end else if (bus.rdy) begin
      case (state_q)
        ST_VEC_LO: begin
          pc_q[7:0] <= bus.rd_data;
          addr_q    <= RESET_VEC + 16'd1;
          state_q   <= ST_VEC_HI;
        end
        ST_VEC_HI: begin
          pc_q[15:8] <= bus.rd_data;
          addr_q     <= {bus.rd_data, pc_q[7:0]};
          sync_q     <= 1'b1;
          state_q    <= ST_FETCH;
        end
        ST_FETCH: begin
          ir_q   <= bus.rd_data;
          pc_q   <= pc_inc;
          sync_q <= 1'b0;
          if (!dec_legal) begin
            addr_q   <= TRAP_ADDR;
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
          end else begin
            addr_q  <= pc_inc;
            state_q <= (dec_cls == CLS_IMPL) ? ST_IMPL : ST_OPER1;
          end
        end
        ST_IMPL: begin
          if (dec_dest == DST_X) begin
            x_q <= x_step;
            p_q <= set_nz(p_q, x_step);
          end
          sync_q  <= 1'b1;
          state_q <= ST_FETCH;
        end
        ST_OPER1: begin
          pc_q   <= pc_inc;
          addr_q <= pc_inc;
          if (dec_cls == CLS_IMM) begin
            case (dec_dest)
              DST_A:   a_q <= bus.rd_data;
              DST_X:   x_q <= bus.rd_data;
              DST_Y:   y_q <= bus.rd_data;
              default: ;
            endcase
            p_q     <= set_nz(p_q, bus.rd_data);
            sync_q  <= 1'b1;
            state_q <= ST_FETCH;
          end else begin
            lo_q    <= bus.rd_data;
            state_q <= ST_OPER2;
          end
        end
        ST_OPER2: begin
          if (ir_q == OP_JMP_ABS) begin
            pc_q    <= {bus.rd_data, lo_q};
            addr_q  <= {bus.rd_data, lo_q};
            sync_q  <= 1'b1;
            state_q <= ST_FETCH;
          end else begin
            pc_q      <= pc_inc;
            addr_q    <= {bus.rd_data, lo_q};
            wr_data_q <= a_q;
            wr_en_q   <= 1'b1;
            state_q   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          wr_en_q <= 1'b0;
          addr_q  <= pc_q;
          sync_q  <= 1'b1;
          state_q <= ST_FETCH;
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign bus.address = addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.sync    = sync_q;
  assign halted      = halted_q;
  assign a_reg       = a_q;
  assign x_reg       = x_q;
  assign y_reg       = y_q;
  assign p_reg       = p_q;

endmodule

// File: tb/tb_proc_core.sv
module tb_proc_core;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  op, b1, b2;
    int          len;
    logic [7:0]  a, x, y, p;
    logic [15:0] next_pc;
    int          cycles;
    int          wr_cycles;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       halted;
  logic [7:0] a_reg, x_reg, y_reg, p_reg;
  logic [7:0] mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;
  int commit_cnt = 0;
  logic [15:0] last_wr_addr = 16'h0;
  logic [7:0]  last_wr_data = 8'h0;

  proc_if bus ();

  proc_core #(
    .RESET_VEC (16'hFFFC),
    .TRAP_ADDR (16'hFFFF),
    .P_RESET   (8'h34)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .halted (halted),
    .a_reg  (a_reg),
    .x_reg  (x_reg),
    .y_reg  (y_reg),
    .p_reg  (p_reg)
  );

  always #5 clk = ~clk;

  assign bus.rd_data = mem[bus.address];

  // Memory-side view of writes: a write commits on an edge with rdy=1.
  always @(posedge clk) begin
    if (resetn && bus.rdy && bus.wr_en) begin
      commit_cnt   <= commit_cnt + 1;
      last_wr_addr <= bus.address;
      last_wr_data <= bus.wr_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance until the next opcode-fetch cycle, counting cycles and write cycles.
  task automatic run_instr(output int cyc, output int wcyc);
    cyc  = 0;
    wcyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.wr_en) wcyc++;
    end while (!bus.sync && cyc < 40);
  endtask

  vec_t vecs [12];

  initial begin
    int cyc, wc, c0, k, whc, bad;

    vecs[0]  = '{16'h8000, 8'hA9, 8'h00, 8'h00, 2, 8'h00, 8'h00, 8'h00, 8'h36, 16'h8002, 2, 0};
    vecs[1]  = '{16'h8002, 8'hA2, 8'h80, 8'h00, 2, 8'h00, 8'h80, 8'h00, 8'hB4, 16'h8004, 2, 0};
    vecs[2]  = '{16'h8004, 8'hA0, 8'h7F, 8'h00, 2, 8'h00, 8'h80, 8'h7F, 8'h34, 16'h8006, 2, 0};
    vecs[3]  = '{16'h8006, 8'hA9, 8'h5A, 8'h00, 2, 8'h5A, 8'h80, 8'h7F, 8'h34, 16'h8008, 2, 0};
    vecs[4]  = '{16'h8008, 8'h8D, 8'h34, 8'h12, 3, 8'h5A, 8'h80, 8'h7F, 8'h34, 16'h800B, 4, 1};
    vecs[5]  = '{16'h800B, 8'hA2, 8'hFF, 8'h00, 2, 8'h5A, 8'hFF, 8'h7F, 8'hB4, 16'h800D, 2, 0};
    vecs[6]  = '{16'h800D, 8'hE8, 8'h00, 8'h00, 1, 8'h5A, 8'h00, 8'h7F, 8'h36, 16'h800E, 2, 0};
    vecs[7]  = '{16'h800E, 8'hCA, 8'h00, 8'h00, 1, 8'h5A, 8'hFF, 8'h7F, 8'hB4, 16'h800F, 2, 0};
    vecs[8]  = '{16'h800F, 8'hEA, 8'h00, 8'h00, 1, 8'h5A, 8'hFF, 8'h7F, 8'hB4, 16'h8010, 2, 0};
    vecs[9]  = '{16'h8010, 8'h4C, 8'h00, 8'h90, 3, 8'h5A, 8'hFF, 8'h7F, 8'hB4, 16'h9000, 3, 0};
    vecs[10] = '{16'h9000, 8'hA0, 8'h00, 8'h00, 2, 8'h5A, 8'hFF, 8'h00, 8'h36, 16'h9002, 2, 0};
    vecs[11] = '{16'h9002, 8'hCA, 8'h00, 8'h00, 1, 8'h5A, 8'hFE, 8'h00, 8'hB4, 16'h9003, 2, 0};

    resetn  = 1'b0;
    bus.rdy = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    for (int i = 0; i < 12; i++) begin
      mem[vecs[i].addr] = vecs[i].op;
      if (vecs[i].len > 1) mem[vecs[i].addr + 16'd1] = vecs[i].b1;
      if (vecs[i].len > 2) mem[vecs[i].addr + 16'd2] = vecs[i].b2;
    end
    // STA $2000 after the table, then an illegal opcode
    mem[16'h9003] = 8'h8D; mem[16'h9004] = 8'h00; mem[16'h9005] = 8'h20;
    mem[16'h9006] = 8'h02;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_addr",    bus.address, 16'hFFFC);
    chk("rst_wr_en",   bus.wr_en,   1'b0);
    chk("rst_sync",    bus.sync,    1'b0);
    chk("rst_halted",  halted,      1'b0);
    chk("rst_wr_data", bus.wr_data, 8'h00);
    chk("rst_regs",    {a_reg, x_reg, y_reg}, 24'h0);
    chk("rst_p",       p_reg,       8'h34);

    // Vector fetch: two cycles to the first opcode fetch
    resetn = 1'b1;
    @(negedge clk);
    chk("vec_hi_addr", bus.address, 16'hFFFD);
    @(negedge clk);
    chk("vec_addr", bus.address, 16'h8000);
    chk("vec_sync", bus.sync, 1'b1);

    // Table-driven instruction stream
    for (int i = 0; i < 12; i++) begin
      run_instr(cyc, wc);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cycles);
      chk($sformatf("v%0d_wr", i),     wc,  vecs[i].wr_cycles);
      chk($sformatf("v%0d_pc", i),     bus.address, vecs[i].next_pc);
      chk($sformatf("v%0d_regs", i),   {a_reg, x_reg, y_reg}, {vecs[i].a, vecs[i].x, vecs[i].y});
      chk($sformatf("v%0d_p", i),      p_reg, vecs[i].p);
    end
    chk("sta_commits",  commit_cnt,   1);
    chk("sta_wr_addr",  last_wr_addr, 16'h1234);
    chk("sta_wr_data",  last_wr_data, 8'h5A);

    // STA with three stalled cycles in WRITE
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.wr_en && k < 10);
    chk("stall_reach_write", k, 3);
    chk("stall_addr",    bus.address, 16'h2000);
    chk("stall_wr_data", bus.wr_data, 8'h5A);
    c0      = commit_cnt;
    bus.rdy = 1'b0;
    whc     = 1;
    repeat (3) begin
      @(negedge clk);
      if (bus.wr_en) whc++;
    end
    bus.rdy = 1'b1;
    @(negedge clk);
    chk("stall_wr_cycles", whc, 4);
    chk("stall_wr_clear",  bus.wr_en, 1'b0);
    chk("stall_commits",   commit_cnt - c0, 1);
    chk("stall_wr_addr",   last_wr_addr, 16'h2000);
    chk("stall_next_pc",   bus.address, 16'h9006);
    chk("stall_sync",      bus.sync, 1'b1);
    chk("stall_regs",      {a_reg, x_reg, y_reg, p_reg}, 32'h5AFE00B4);

    // Illegal opcode 02 traps and holds regardless of rdy
    @(negedge clk);
    chk("halt_flag", halted, 1'b1);
    chk("halt_addr", bus.address, 16'hFFFF);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      bus.rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!halted || bus.address !== 16'hFFFF || bus.wr_en || bus.sync) bad++;
    end
    bus.rdy = 1'b1;
    chk("halt_hold", bad, 0);
    chk("halt_regs", {a_reg, x_reg, y_reg, p_reg}, 32'h5AFE00B4);

    // JMP loop at A000: back at A000 every 3 cycles
    resetn = 1'b0;
    mem[16'hFFFD] = 8'hA0;
    mem[16'hA000] = 8'h4C; mem[16'hA001] = 8'h00; mem[16'hA002] = 8'hA0;
    @(negedge clk);
    chk("halt_cleared", halted, 1'b0);
    resetn = 1'b1;
    run_instr(cyc, wc);
    chk("loop_start_cycles", cyc, 2);
    for (int i = 0; i < 3; i++) begin
      run_instr(cyc, wc);
      chk($sformatf("loop%0d_cycles", i), cyc, 3);
      chk($sformatf("loop%0d_addr", i), bus.address, 16'hA000);
    end

    // Reset asserted while the STA write is on the bus
    resetn = 1'b0;
    mem[16'hFFFD] = 8'hB0;
    mem[16'hB000] = 8'h8D; mem[16'hB001] = 8'h00; mem[16'hB002] = 8'h30;
    @(negedge clk);
    resetn = 1'b1;
    run_instr(cyc, wc);
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.wr_en && k < 10);
    chk("rstsw_reach_write", k, 3);
    c0     = commit_cnt;
    resetn = 1'b0;
    #1;
    chk("rstsw_wr_en", bus.wr_en,   1'b0);
    chk("rstsw_addr",  bus.address, 16'hFFFC);
    chk("rstsw_sync",  bus.sync,    1'b0);
    repeat (2) @(negedge clk);
    chk("rstsw_no_commit", commit_cnt - c0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
